// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, one buffered MDU result drains into free slots.
// Also keeps a pending-write scoreboard for decode RAW hazards and forces a WB bubble when the buffer starves.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [4:0]        pipe_rd,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              mdu_issue,
  input  logic [4:0]        mdu_issue_rd,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_rd,
  input  logic [DATA_W-1:0] mdu_wd,
  output logic              mdu_ready,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              hazard,
  output logic              stall_pipe,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam logic [3:0] STALL_AT = 4'(MAX_WAIT - 1);

  logic              hold_valid;
  logic [4:0]        hold_rd;
  logic [DATA_W-1:0] hold_wd;
  logic [3:0]        wait_cnt;
  logic [31:0]       pending;

  logic              pipe_wr;
  logic              grant_hold;
  logic              accept;
  logic              load;
  logic [31:0]       set_mask;
  logic [31:0]       clr_mask;
  logic [31:0]       pending_next;

  // A write to x0 is not a write, so it leaves the port free for the hold register.
  assign pipe_wr    = pipe_we && (pipe_rd != 5'd0);
  assign grant_hold = hold_valid && !pipe_wr;
  assign mdu_ready  = !hold_valid || grant_hold;
  assign accept     = mdu_valid && mdu_ready;
  assign load       = accept && (mdu_rd != 5'd0);

  assign rf_we    = pipe_wr || grant_hold;
  assign rf_waddr = pipe_wr ? pipe_rd : hold_rd;
  assign rf_wdata = pipe_wr ? pipe_wd : hold_wd;

  assign hazard = ((rs1 != 5'd0) && pending[rs1]) || ((rs2 != 5'd0) && pending[rs2]);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (mdu_issue) set_mask[mdu_issue_rd] = 1'b1;
    if (grant_hold) clr_mask[hold_rd] = 1'b1;
    // Set is applied after clear so a re-issue to the draining register stays pending.
    pending_next = ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      wait_cnt   <= 4'd0;
      stall_pipe <= 1'b0;
      pending    <= '0;
    end else begin
      if (load) hold_valid <= 1'b1;
      else if (grant_hold) hold_valid <= 1'b0;

      // Saturate so a long protocol-violating pipe stream cannot wrap and re-trigger.
      if (!hold_valid || grant_hold) wait_cnt <= 4'd0;
      else if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;

      if (grant_hold) stall_pipe <= 1'b0;
      else if (hold_valid && (wait_cnt == STALL_AT)) stall_pipe <= 1'b1;

      pending <= pending_next;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hold_rd <= mdu_rd;
      hold_wd <= mdu_wd;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a transaction-level reference model.
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int DATA_W   = 32;

  logic              clk;
  logic              reset;
  logic              pipe_we;
  logic [4:0]        pipe_rd;
  logic [DATA_W-1:0] pipe_wd;
  logic              mdu_issue;
  logic [4:0]        mdu_issue_rd;
  logic              mdu_valid;
  logic [4:0]        mdu_rd;
  logic [DATA_W-1:0] mdu_wd;
  logic              mdu_ready;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              hazard;
  logic              stall_pipe;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a one-deep result buffer, a consecutive-loss count, and a set of pending registers.
  typedef struct {
    logic [4:0]        rd;
    logic [DATA_W-1:0] wd;
  } res_t;
  res_t hold_q[$];
  bit   pend[32];
  int   losses;
  bit   m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    mdu_issue = 0; mdu_issue_rd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_wd = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic check_now();
    bit pw, gh;
    #1;
    pw = pipe_we && (pipe_rd != 0);
    gh = (hold_q.size() != 0) && !pw;
    chk("rf_we", rf_we, pw || gh);
    if (pw) begin
      chk("rf_waddr_pipe", rf_waddr, pipe_rd);
      chk("rf_wdata_pipe", rf_wdata, pipe_wd);
    end else if (gh) begin
      chk("rf_waddr_hold", rf_waddr, hold_q[0].rd);
      chk("rf_wdata_hold", rf_wdata, hold_q[0].wd);
    end
    chk("mdu_ready", mdu_ready, (hold_q.size() == 0) || gh);
    chk("hazard", hazard, ((rs1 != 0) && pend[rs1]) || ((rs2 != 0) && pend[rs2]));
    chk("stall_pipe", stall_pipe, m_stall);
  endtask

  task automatic tick();
    bit pw, gh, acc;
    pw  = pipe_we && (pipe_rd != 0);
    gh  = (hold_q.size() != 0) && !pw;
    acc = mdu_valid && ((hold_q.size() == 0) || gh);
    @(posedge clk);
    if (reset) begin
      hold_q.delete();
      pend = '{default: 0};
      losses = 0;
      m_stall = 0;
    end else begin
      if (gh) begin
        pend[hold_q[0].rd] = 0;
        void'(hold_q.pop_front());
        losses = 0;
        m_stall = 0;
      end else if (hold_q.size() != 0) begin
        losses++;
        if (losses >= MAX_WAIT) m_stall = 1;
      end
      if (acc && (mdu_rd != 0)) begin
        hold_q.push_back('{mdu_rd, mdu_wd});
        losses = 0;
      end
      if (mdu_issue && (mdu_issue_rd != 0)) pend[mdu_issue_rd] = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1;
    losses = 0;
    m_stall = 0;
    @(negedge clk);
    tick();
    tick();
    reset = 0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check_now();
      chk("idle_ready", mdu_ready, 1);
      chk("idle_hazard", hazard, 0);
      chk("idle_rf_we", rf_we, 0);
      chk("idle_stall", stall_pipe, 0);
      tick();
    end

    // Pipe write, zero latency; x0 write suppressed
    pipe_we = 1; pipe_rd = 5; pipe_wd = 32'h1234;
    check_now();
    chk("pipe_we", rf_we, 1);
    chk("pipe_addr", rf_waddr, 5);
    chk("pipe_data", rf_wdata, 32'h1234);
    tick();
    pipe_rd = 0;
    check_now();
    chk("pipe_x0", rf_we, 0);
    tick();
    idle();

    // RAW hazard lifetime for rd=9
    mdu_issue = 1; mdu_issue_rd = 9; rs1 = 9;
    check_now(); tick();
    mdu_issue = 0;
    for (int i = 1; i < 3; i++) begin
      check_now();
      chk("raw_pending", hazard, 1);
      tick();
    end
    mdu_valid = 1; mdu_rd = 9; mdu_wd = 100;
    check_now(); chk("raw_c3_hazard", hazard, 1); tick();
    mdu_valid = 0;
    check_now();
    chk("raw_c4_we", rf_we, 1);
    chk("raw_c4_addr", rf_waddr, 9);
    chk("raw_c4_data", rf_wdata, 100);
    chk("raw_c4_hazard", hazard, 1);
    tick();
    check_now(); chk("raw_c5_hazard", hazard, 0); tick();
    idle();

    // Starved hold raises stall_pipe
    pipe_we = 1; pipe_rd = 1; pipe_wd = 32'hAAAA;
    mdu_issue = 1; mdu_issue_rd = 7;
    mdu_valid = 1; mdu_rd = 7; mdu_wd = 32'h77;
    check_now(); chk("starve_accept", mdu_ready, 1); tick();
    mdu_issue = 0; mdu_valid = 0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      pipe_wd = $urandom;
      check_now();
      chk("starve_no_stall", stall_pipe, 0);
      chk("starve_ready", mdu_ready, 0);
      tick();
    end
    pipe_we = 0; rs1 = 7;
    check_now();
    chk("starve_stall", stall_pipe, 1);
    chk("starve_drain_we", rf_we, 1);
    chk("starve_drain_addr", rf_waddr, 7);
    chk("starve_drain_data", rf_wdata, 32'h77);
    tick();
    check_now();
    chk("starve_unstall", stall_pipe, 0);
    chk("starve_pending7", hazard, 0);
    tick();
    idle();

    // Back-to-back MDU results, then a discarded x0 result
    for (int i = 0; i < 4; i++) begin
      mdu_valid = (i < 3);
      mdu_rd = 5'(3 + i);
      mdu_wd = 32'(1000 + i);
      check_now();
      chk("b2b_ready", mdu_ready, 1);
      if (i > 0) begin
        chk("b2b_we", rf_we, 1);
        chk("b2b_addr", rf_waddr, 2 + i);
      end
      tick();
    end
    mdu_valid = 1; mdu_rd = 0; mdu_wd = 32'hDEAD;
    check_now(); chk("x0_ready", mdu_ready, 1); tick();
    mdu_valid = 0;
    check_now(); chk("x0_no_write", rf_we, 0); tick();

    // Re-issue to the register being drained keeps it pending
    mdu_issue = 1; mdu_issue_rd = 6; mdu_valid = 1; mdu_rd = 6; mdu_wd = 32'h66;
    check_now(); tick();
    mdu_valid = 0; rs1 = 6;
    check_now();
    chk("setwin_drain", rf_waddr, 6);
    tick();
    mdu_issue = 0;
    check_now(); chk("setwin_pending6", hazard, 1); tick();
    idle();

    // Reset drops a buffered result
    pipe_we = 1; pipe_rd = 2; pipe_wd = 32'h22;
    mdu_issue = 1; mdu_issue_rd = 10; mdu_valid = 1; mdu_rd = 10; mdu_wd = 32'hABC;
    check_now(); tick();
    mdu_issue = 0; mdu_valid = 0; rs1 = 10; reset = 1;
    check_now(); chk("rst_pipe_addr", rf_waddr, 2); tick();
    reset = 0; pipe_we = 0;
    check_now();
    chk("rst_no_write", rf_we, 0);
    chk("rst_ready", mdu_ready, 1);
    chk("rst_hazard", hazard, 0);
    chk("rst_stall", stall_pipe, 0);
    tick();
    idle();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      pipe_we      = ($urandom_range(0, 99) < (m_stall ? 15 : 60));
      pipe_rd      = 5'($urandom_range(0, 7));
      pipe_wd      = $urandom;
      mdu_issue    = ($urandom_range(0, 99) < 30);
      mdu_issue_rd = 5'($urandom_range(0, 7));
      mdu_valid    = ($urandom_range(0, 99) < 40);
      mdu_rd       = 5'($urandom_range(0, 7));
      mdu_wd       = $urandom;
      rs1          = 5'($urandom_range(0, 7));
      rs2          = 5'($urandom_range(0, 7));
      check_now();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
